// File: rtl/fme_arbiter.sv
// fme_arbiter: two-requester round-robin front end for one shared
// modular-exponentiation engine. A request is granted in IDLE, its operands
// are latched and launched, and the owner receives a one-cycle done pulse
// when the engine answers.
// Optional watchdog: define FME_ARB_TIMEOUT_EN to abort jobs that exceed
// TIMEOUT_CYCLES cycles in WAIT; without it timeout is tied low.
module fme_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [63:0] base,
  input  logic [63:0] exponent,
  input  logic [63:0] modulo,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [31:0] result,
  output logic        busy,
  output logic        timeout,
  output logic        fme_start,
  output logic [31:0] fme_base,
  output logic [31:0] fme_exponent,
  output logic [31:0] fme_modulo,
  input  logic [31:0] fme_result,
  input  logic        fme_done
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESPOND} state_t;

  state_t state;
  state_t state_nxt;
  logic   last;    // index of the requester granted most recently
  logic   win;     // index of the requester that wins in the current IDLE cycle
  logic   expire;  // watchdog limit reached in this WAIT cycle

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fme_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  // Select one requester's 32-bit slice out of a packed {slice1, slice0} pair.
  function automatic logic [DATA_W-1:0] pick(input logic [2*DATA_W-1:0] pair,
                                             input logic               sel);
    return sel ? pair[2*DATA_W-1:DATA_W] : pair[DATA_W-1:0];
  endfunction

  // Round-robin winner: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) win = ~last;
    else              win = req[1];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and the state-decoded outputs.
  always_comb begin
    state_nxt = state;
    fme_start = 1'b0;
    busy      = 1'b1;
    done      = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (|req) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        fme_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // fme_done is only meaningful here; it is ignored in every other state.
        if (fme_done || expire) state_nxt = RESPOND;
      end
      RESPOND: begin
        done      = gnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, operand latch and result capture; reset clears everything so an
  // abandoned job leaves no trace on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt          <= '0;
      last         <= 1'b1;
      fme_base     <= '0;
      fme_exponent <= '0;
      fme_modulo   <= '0;
      result       <= '0;
    end else begin
      if (state == IDLE && req != 2'b00) begin
        gnt          <= win ? 2'b10 : 2'b01;
        last         <= win;
        fme_base     <= pick(base, win);
        fme_exponent <= pick(exponent, win);
        fme_modulo   <= pick(modulo, win);
      end else if (state == RESPOND) begin
        gnt <= '0;
      end
      if (state == WAIT && fme_done)    result <= fme_result;
      else if (state == WAIT && expire) result <= '0;
    end
  end

`ifdef FME_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            tmo_flag;

  // Watchdog counter: held at zero outside WAIT, so every WAIT entry starts from zero.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wd_cnt <= '0;
    else                      wd_cnt <= wd_cnt + 1'b1;
  end

  // The last permitted WAIT cycle is the one with count TIMEOUT_CYCLES-1.
  assign expire = (state == WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Timeout pulse lines up with the owner's done pulse; a coincident fme_done wins.
  always_ff @(posedge clk) begin
    if (rst) tmo_flag <= 1'b0;
    else     tmo_flag <= expire && !fme_done;
  end

  assign timeout = tmo_flag;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fme_arbiter.sv
// tb_fme_arbiter: table-driven jobs plus hand-written corner sequences for
// fme_arbiter, with a behavioural engine and an expected-result scoreboard.
`timescale 1ns/1ps
module tb_fme_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [63:0] base, exponent, modulo;
  logic [1:0]  gnt, done;
  logic [31:0] result;
  logic        busy, timeout, fme_start;
  logic [31:0] fme_base, fme_exponent, fme_modulo;
  logic [31:0] fme_result;
  logic        fme_done;

  always #5 clk = ~clk;

  fme_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req(req), .base(base), .exponent(exponent),
    .modulo(modulo), .gnt(gnt), .done(done), .result(result), .busy(busy),
    .timeout(timeout), .fme_start(fme_start), .fme_base(fme_base),
    .fme_exponent(fme_exponent), .fme_modulo(fme_modulo),
    .fme_result(fme_result), .fme_done(fme_done)
  );

  typedef struct {
    logic [1:0]  gnt;
    logic [31:0] res;
    logic        tmo;
  } exp_t;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] b0, e0, m0, b1, e1, m1;
    int          lat;
    logic [1:0]  exp_gnt;
    logic [31:0] exp_res;
    logic [31:0] exp_res2;
  } vec_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_done_cyc = -10;
  bit          eng_en;
  int          eng_lat;
  int          stray_cnt;
  int          stray_seen;
  logic [31:0] stray_val;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_modexp(input logic [31:0] b, input logic [31:0] e,
                                             input logic [31:0] m);
    logic [63:0] r, x, mm;
    logic [31:0] k;
    if (m == 0) return 32'd0;
    mm = {32'd0, m};
    r  = 64'd1 % mm;
    x  = {32'd0, b} % mm;
    k  = e;
    while (k != 0) begin
      if (k[0]) r = (r * x) % mm;
      x = (x * x) % mm;
      k = k >> 1;
    end
    return r[31:0];
  endfunction

  // Behavioural engine: answers eng_lat cycles after fme_start, or emits a stray pulse on demand.
  initial begin
    logic [31:0] r;
    fme_done   = 1'b0;
    fme_result = '0;
    stray_seen = 0;
    forever begin
      @(negedge clk);
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        @(posedge clk); #1 fme_done = 1'b1; fme_result = stray_val;
        @(posedge clk); #1 fme_done = 1'b0;
      end else if (fme_start && eng_en) begin
        r = ref_modexp(fme_base, fme_exponent, fme_modulo);
        repeat (eng_lat) @(posedge clk);
        #1 fme_done = 1'b1; fme_result = r; last_done_cyc = cyc;
        @(posedge clk); #1 fme_done = 1'b0;
      end
    end
  end

  // Scoreboard side: every done pulse is matched against the oldest expected job.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fme_start) begin
        chk("start_onehot", 64'($onehot(gnt)), 64'd1);
        chk("start_base", fme_base, gnt[1] ? base[63:32] : base[31:0]);
        chk("start_mod", fme_modulo, gnt[1] ? modulo[63:32] : modulo[31:0]);
      end
      if (timeout && done == 2'b00) chk("timeout_alone", timeout, 0);
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          e = sb.pop_front();
          chk("done_owner", done, e.gnt);
          chk("done_result", result, e.res);
          chk("done_timeout", timeout, e.tmo);
          if (!e.tmo) chk("done_latency", cyc, last_done_cyc + 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "global timeout");
  end

  task automatic wait_done(output logic [1:0] d);
    d = 2'b00;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        d = done;
        break;
      end
    end
    if (d == 2'b00) begin
      total++;
      bad++;
      $display("FAIL wait_done: got no done pulse in 300 cycles, want one");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_start"}, fme_start, 0);
    chk({tag, "_fbase"}, fme_base, 0);
    chk({tag, "_fexp"}, fme_exponent, 0);
    chk({tag, "_fmod"}, fme_modulo, 0);
  endtask

  // Runs one table entry; a request of 11 yields two jobs, winner first.
  task automatic run_vec(input vec_t v);
    logic [1:0] d;
    int n;
    base     = {v.b1, v.b0};
    exponent = {v.e1, v.e0};
    modulo   = {v.m1, v.m0};
    eng_lat  = v.lat;
    sb.push_back(exp_t'{v.exp_gnt, v.exp_res, 1'b0});
    if (v.req == 2'b11) sb.push_back(exp_t'{~v.exp_gnt, v.exp_res2, 1'b0});
    req = v.req;
    @(negedge clk);
    chk("idle_gnt", gnt, 0);
    chk("idle_start", fme_start, 0);
    @(negedge clk);
    chk("launch_gnt", gnt, v.exp_gnt);
    chk("launch_start", fme_start, 1);
    @(negedge clk);
    chk("wait_start", fme_start, 0);
    chk("wait_busy", busy, 1);
    chk("wait_gnt", gnt, v.exp_gnt);
    n = (v.req == 2'b11) ? 2 : 1;
    for (int k = 0; k < n; k++) begin
      wait_done(d);
      @(posedge clk); #1 req = req & ~d;
      @(negedge clk);
      chk("after_gnt", gnt, 0);
      chk("after_busy", busy, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t        vecs[6];
    logic [31:0] ab[4], ae[4], am[4], ar[4];
    logic [1:0]  d;
    int          w;
    bit          seen_done, seen_busy;

    vecs[0] = '{2'b01, 4, 13, 497, 0, 0, 0, 20, 2'b01, 445, 0};
    vecs[1] = '{2'b10, 0, 0, 0, 2, 10, 1000, 5, 2'b10, 24, 0};
    vecs[2] = '{2'b11, 3, 5, 7, 5, 0, 13, 2, 2'b01, 5, 1};
    vecs[3] = '{2'b01, 123, 45, 1, 0, 0, 0, 3, 2'b01, 0, 0};
    vecs[4] = '{2'b11, 7, 2, 50, 10, 3, 7, 1, 2'b10, 6, 49};
    vecs[5] = '{2'b10, 0, 0, 0, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFB, 7, 2'b10, 64, 0};

    rst = 1'b1; req = 2'b00; base = '0; exponent = '0; modulo = '0;
    eng_en = 1'b1; eng_lat = 4; stray_cnt = 0; stray_val = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Table of single and paired jobs.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // fme_done while idle must leave the block untouched.
    stray_val = 32'd999;
    stray_cnt++;
    seen_done = 1'b0; seen_busy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done != 2'b00) seen_done = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    chk("idle_stray_done", seen_done, 0);
    chk("idle_stray_busy", seen_busy, 0);
    chk("idle_stray_result", result, 64);
    @(posedge clk); #1;

    // Both requesters asking continuously for four distinct jobs: 0,1,0,1.
    do_reset();
    ab = '{4, 2, 3, 10}; ae = '{13, 10, 5, 3}; am = '{497, 1000, 7, 7};
    ar = '{445, 24, 5, 6};
    for (int j = 0; j < 4; j++) sb.push_back(exp_t'{(j % 2 == 0) ? 2'b01 : 2'b10, ar[j], 1'b0});
    base = {ab[1], ab[0]}; exponent = {ae[1], ae[0]}; modulo = {am[1], am[0]};
    eng_lat = 3;
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_done(d);
      chk("alt_owner", d, (j % 2 == 0) ? 2'b01 : 2'b10);
      if (j + 2 < 4) begin
        if (j % 2 == 0) begin
          base[31:0] = ab[j+2]; exponent[31:0] = ae[j+2]; modulo[31:0] = am[j+2];
        end else begin
          base[63:32] = ab[j+2]; exponent[63:32] = ae[j+2]; modulo[63:32] = am[j+2];
        end
      end else begin
        @(posedge clk); #1 req = req & ~d;
      end
    end
    @(negedge clk);
    chk("alt_end_busy", busy, 0);
    @(posedge clk); #1;

`ifdef FME_ARB_TIMEOUT_EN
    // Engine never answers: watchdog aborts 16 cycles after WAIT entry.
    eng_en = 1'b0;
    base[63:32] = 32'd9; exponent[63:32] = 32'd9; modulo[63:32] = 32'd11;
    sb.push_back(exp_t'{2'b10, 32'd0, 1'b1});
    req = 2'b10;
    @(negedge clk);
    @(negedge clk);
    chk("tmo_launch", fme_start, 1);
    @(posedge clk); #1 w = cyc;
    wait_done(d);
    chk("tmo_latency", cyc - w, 16);
    chk("tmo_pulse", timeout, 1);
    @(posedge clk); #1 req = 2'b00;
    @(negedge clk);
    chk("tmo_idle_busy", busy, 0);
    chk("tmo_idle_timeout", timeout, 0);
    @(posedge clk); #1;
    eng_en = 1'b1;
`endif

    // Reset in WAIT abandons the job; a later stray fme_done is ignored.
    eng_en = 1'b0;
    base[31:0] = 32'd5; exponent[31:0] = 32'd3; modulo[31:0] = 32'd13;
    req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_launch", fme_start, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rstw_busy", busy, 1);
    @(posedge clk); #1 rst = 1'b1; req = 2'b00;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("rstw");
    stray_val = 32'd77;
    stray_cnt++;
    seen_done = 1'b0; seen_busy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done != 2'b00) seen_done = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    chk("rstw_stray_done", seen_done, 0);
    chk("rstw_stray_busy", seen_busy, 0);
    chk("rstw_stray_result", result, 0);
    eng_en = 1'b1;

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fme_arbiter.md
FME_ARBITER -- requirements
Module: fme_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the watchdog limit in clk cycles (used only when FME_ARB_TIMEOUT_EN is defined).
REQ-002 The block SHALL have port clk, input, 1, the system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous, active-high.
REQ-004 The block SHALL have port req, input, 2, per-requester level request; bit i is held from assertion until done[i] is sampled high.
REQ-005 The block SHALL have port base, input, 64, operands packed as {base1, base0}, each 32 bits.
REQ-006 The block SHALL have port exponent, input, 64, packed as {exp1, exp0}.
REQ-007 The block SHALL have port modulo, input, 64, packed as {mod1, mod0}.
REQ-008 The block SHALL have port gnt, output, 2, one-hot owner of the engine; all zero when the engine is not owned.
REQ-009 The block SHALL have port done, output, 2, one-cycle completion pulse for the owner.
REQ-010 The block SHALL have port result, output, 32, the result of the last completed job.
REQ-011 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 The block SHALL have port timeout, output, 1, one-cycle pulse when the watchdog aborts a job.
REQ-013 The block SHALL have ports fme_start (output, 1), fme_base, fme_exponent and fme_modulo (outputs, 32 each), which drive the shared modular-exponentiation engine.
REQ-014 The block SHALL have ports fme_result (input, 32) and fme_done (input, 1, one-cycle pulse), which are the engine's outputs.

Function
REQ-015 FSM states: IDLE, LAUNCH, WAIT, RESPOND.
- IDLE to LAUNCH when any req bit is high.
- LAUNCH to WAIT unconditionally.
- WAIT to RESPOND on fme_done, or on watchdog expiry.
- RESPOND to IDLE unconditionally.
REQ-016 Selection in IDLE is round-robin:
- With a single request, that requester wins.
- With both requesting, the requester not granted last wins.
- After reset, requester 0 has priority.
REQ-017 On leaving IDLE, the winner's base, exponent and modulo slices SHALL be latched onto fme_base, fme_exponent and fme_modulo, and gnt SHALL be set one-hot; both are held until RESPOND ends.
REQ-018 fme_start SHALL be high for exactly the LAUNCH cycle.
REQ-019 Latency: req sampled in IDLE at cycle T gives gnt and fme_start at T+1; fme_done at cycle D gives done[owner] and updated result at D+1.
REQ-020 result SHALL capture fme_result on the fme_done cycle and hold it until the next capture.
REQ-021 fme_done received in IDLE, LAUNCH or RESPOND SHALL be ignored.
REQ-022 req is not re-sampled until IDLE, so a requester that drops req at the edge where it samples done[i] high is not re-granted.
REQ-023 A req bit that drops while a job is in flight SHALL NOT cancel the job; the done pulse is still issued.
REQ-024 gnt SHALL clear in IDLE; the last-grant pointer SHALL update when leaving IDLE.

Reset
REQ-025 rst SHALL force state IDLE and clear gnt, done, result, busy, timeout, fme_start, all fme_* operand outputs and the watchdog counter; the pointer is set to favour requester 0.
REQ-026 rst asserted mid-job (LAUNCH or WAIT) SHALL abandon the job without a done pulse; a later fme_done is ignored per REQ-021.

Configuration
REQ-027 With macro FME_ARB_TIMEOUT_EN defined:
- A counter SHALL clear on entering WAIT and increment each WAIT cycle.
- If the counter reaches TIMEOUT_CYCLES without fme_done, the FSM goes to RESPOND, pulses timeout together with done[owner], and sets result to 0.
- If fme_done and expiry coincide, fme_done wins.
REQ-028 Without FME_ARB_TIMEOUT_EN:
- No counter is synthesised.
- timeout is tied to 0.
- WAIT exits only on fme_done.

Verification
REQ-029 req=01, base0=4, exp0=13, mod0=497, engine model returns 445 twenty cycles after fme_start -> gnt=01 one cycle after req, a single fme_start, done=01 with result=445 one cycle after fme_done.
REQ-030 req=11 immediately after reset, each job is distinct -> requester 0 is served first, then requester 1, with the correct result per job and gnt never 11.
REQ-031 Both requesters re-request continuously for four jobs -> grants alternate 0,1,0,1.
REQ-032 With FME_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, engine never asserts fme_done -> timeout and done[owner] pulse together, 16 cycles after WAIT entry, with result=0, then return to IDLE.
REQ-033 rst asserted in WAIT, followed by a stray fme_done -> all outputs are 0 and no done pulse occurs.
REQ-034 fme_done pulsed while in IDLE -> no state change and result unchanged.
